fetch_ctrl: RTL and testbench

//  Front-end fetch sequencer; owns the program counter. Each cycle it chooses the

---
 rtl/fetch_ctrl_if.sv | 29 ++
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: stall sources, branch redirect and halt requests in,
// PC / flush / status out. The sequencer sits on the slave side.
interface fetch_ctrl_if #(
    parameter int N_STALL = 3,
    parameter int CNT_W   = 16
);
    localparam int CAUSE_W = (N_STALL > 1) ? $clog2(N_STALL) : 1;

    logic [N_STALL-1:0] stall_req;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               halt_req;
    logic [31:0]        pc;
    logic               fetch_valid;
    logic               flush;
    logic               halted;
    logic [CAUSE_W-1:0] stall_cause;
    logic [CNT_W-1:0]   stall_cycles;

    modport master (
        output stall_req, redirect_valid, redirect_pc, halt_req,
        input  pc, fetch_valid, flush, halted, stall_cause, stall_cycles
    );

    modport slave (
        input  stall_req, redirect_valid, redirect_pc, halt_req,
        output pc, fetch_valid, flush, halted, stall_cause, stall_cycles
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer. Owns the program counter and picks the next PC
// each cycle from redirect > halt > stall > advance. A redirect raises flush
// for FLUSH_CYCLES cycles after the last redirect; halt is sticky until a
// redirect (the halting instruction may have been speculative) or reset.
module fetch_ctrl #(
    parameter int          N_STALL      = 3,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          CNT_W        = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_ctrl_if.slave   bus
);
    localparam int CAUSE_W = (N_STALL > 1) ? $clog2(N_STALL) : 1;
    localparam int FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              halted_q, halted_d;
    logic [FC_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic              stall_any;
    logic [31:0]       redirect_aligned;
    logic              fetch_valid;
    logic [CAUSE_W-1:0] stall_cause;

    assign stall_any        = |bus.stall_req;
    // Targets are word aligned; the low two bits of the redirect are dropped.
    assign redirect_aligned = bus.redirect_pc & ~32'h3;

    // State register: FSM state, PC, flush/halt flags, flush countdown, perf counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
        end
    end

    // Next-state logic: redirect beats everything, then halt, then stall, then advance.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = flush_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        stall_d  = stall_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    pc_d    = redirect_aligned;
                    flush_d = 1'b1;
                    cnt_d   = FLUSH_RELOAD;
                    state_d = ST_FLUSH;
                end else if (bus.halt_req) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (stall_any) begin
                    if (stall_q != STALL_MAX) begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_FLUSH: begin
                // Stalls and halts are meaningless while younger work is being killed.
                if (bus.redirect_valid) begin
                    pc_d  = redirect_aligned;
                    cnt_d = FLUSH_RELOAD;
                end else if (cnt_q == '0) begin
                    flush_d = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - FC_W'(1);
                end
            end
            ST_HALT: begin
                // A late redirect proves the halting instruction was on a wrong path.
                if (bus.redirect_valid) begin
                    halted_d = 1'b0;
                    pc_d     = redirect_aligned;
                    flush_d  = 1'b1;
                    cnt_d    = FLUSH_RELOAD;
                    state_d  = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output logic: fetch qualifier and lowest-index stall source.
    always_comb begin
        fetch_valid = (state_q == ST_RUN) && !stall_any &&
                      !bus.redirect_valid && !bus.halt_req;
        stall_cause = '0;
        for (int i = N_STALL - 1; i >= 0; i--) begin
            if (bus.stall_req[i]) begin
                stall_cause = CAUSE_W'(i);
            end
        end
    end

    assign bus.pc           = pc_q;
    assign bus.flush        = flush_q;
    assign bus.halted       = halted_q;
    assign bus.stall_cycles = stall_q;
    assign bus.fetch_valid  = fetch_valid;
    assign bus.stall_cause  = stall_cause;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model that tracks remaining flush cycles as a plain integer.
module tb_fetch_ctrl;
    localparam int N_STALL = 3;
    localparam int FC      = 2;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    logic clk;
    logic reset_n;

    fetch_ctrl_if #(.N_STALL(N_STALL), .CNT_W(CNT_W)) bus ();

    fetch_ctrl #(
        .N_STALL(N_STALL), .FLUSH_CYCLES(FC), .RESET_PC(32'h0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_halted;
    int          m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_flush_left = 0; m_halted = 0; m_stall = 0;
    endtask

    function automatic logic [31:0] exp_cause(input logic [2:0] st);
        for (int i = 0; i < N_STALL; i++) if (st[i]) return i;
        return 0;
    endfunction

    task automatic model_step(input logic [2:0] st, input logic rv,
                              input logic [31:0] rpc, input logic hr);
        if (rv) begin
            m_pc = {rpc[31:2], 2'b00};
            m_flush_left = FC;
            m_halted = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_halted) begin
        end else if (hr) begin
            m_halted = 1;
        end else if (st != 0) begin
            if (m_stall < CNT_MAX) m_stall++;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_pc"}, bus.pc, m_pc);
        chk({tag, "_flush"}, 32'(bus.flush), 32'(m_flush_left > 0));
        chk({tag, "_halted"}, 32'(bus.halted), 32'(m_halted));
        chk({tag, "_stallcyc"}, 32'(bus.stall_cycles), 32'(m_stall));
    endtask

    // One clock: drive inputs, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input logic [2:0] st, input logic rv,
                         input logic [31:0] rpc, input logic hr);
        bit fv;
        bus.stall_req = st; bus.redirect_valid = rv;
        bus.redirect_pc = rpc; bus.halt_req = hr;
        #1;
        fv = (m_flush_left == 0) && !m_halted && (st == 0) && !rv && !hr;
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(fv));
        chk("stall_cause", 32'(bus.stall_cause), exp_cause(st));
        @(posedge clk);
        model_step(st, rv, rpc, hr);
        #1;
        check_regs("cyc");
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(3'b000, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        bus.stall_req = '0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.halt_req = 0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_regs("rst");
        chk("rst_fv", 32'(bus.fetch_valid), 32'd1);
        @(posedge clk); #1;
        check_regs("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] frozen_pc;
        reset_n = 1'b1;
        bus.stall_req = '0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.halt_req = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: sequential fetch from reset
        for (int i = 0; i < 5; i++) begin
            chk("t1_pc", bus.pc, 32'(i * 4));
            idle();
        end

        // 2: stall at pc=8 from sources 1 and 2
        do_reset();
        idle(); idle();
        chk("t2_pc8", bus.pc, 32'h8);
        for (int i = 0; i < 3; i++) begin
            cycle(3'b110, 0, 0, 0);
            chk("t2_hold", bus.pc, 32'h8);
        end
        chk("t2_stallcyc", 32'(bus.stall_cycles), 32'd3);
        idle();
        chk("t2_adv", bus.pc, 32'hC);

        // 3: redirect with misaligned target
        cycle(3'b000, 1, 32'h103, 0);
        chk("t3_pc", bus.pc, 32'h100);
        chk("t3_flush1", 32'(bus.flush), 32'd1);
        idle();
        chk("t3_flush2", 32'(bus.flush), 32'd1);
        idle();
        chk("t3_flush_off", 32'(bus.flush), 32'd0);
        #1 chk("t3_fv", 32'(bus.fetch_valid), 32'd1);
        idle();
        chk("t3_adv", bus.pc, 32'h104);

        // 4: second redirect stretches flush; stalls during flush not counted
        cycle(3'b000, 1, 32'h300, 0);
        idle();
        cycle(3'b111, 1, 32'h200, 0);
        chk("t4_pc", bus.pc, 32'h200);
        cycle(3'b011, 0, 0, 0);
        chk("t4_flush_a", 32'(bus.flush), 32'd1);
        cycle(3'b100, 0, 0, 1);
        chk("t4_flush_b", 32'(bus.flush), 32'd0);
        chk("t4_stallcyc", 32'(bus.stall_cycles), 32'd3);

        // 5: halt wins over stall, stays halted, redirect resumes
        cycle(3'b001, 0, 0, 1);
        chk("t5_halted", 32'(bus.halted), 32'd1);
        frozen_pc = bus.pc;
        for (int i = 0; i < 10; i++) begin
            cycle(3'($urandom), 0, $urandom, 1'($urandom));
            chk("t5_frozen", bus.pc, frozen_pc);
        end
        cycle(3'b000, 1, 32'h40, 0);
        chk("t5_unhalt", 32'(bus.halted), 32'd0);
        chk("t5_flush", 32'(bus.flush), 32'd1);
        idle(); idle();
        idle();
        chk("t5_resume", bus.pc, 32'h44);

        // 6: pc wrap, counter saturation, reset during flush
        cycle(3'b000, 1, 32'hFFFF_FFFF, 0);
        chk("t6_top", bus.pc, 32'hFFFF_FFFC);
        idle(); idle();
        idle();
        chk("t6_wrap", bus.pc, 32'h0);
        for (int i = 0; i < CNT_MAX + 4; i++) cycle(3'b100, 0, 0, 0);
        chk("t6_sat", 32'(bus.stall_cycles), 32'hFFFF);
        cycle(3'b000, 1, 32'h500, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_regs("t6_async_rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
                      $urandom_range(0, 15) == 0, $urandom,
                      $urandom_range(0, 31) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
